// File: rtl/param_step_counter_pkg.sv
// Shared constants and elaboration helpers
// for the parametrised step counter.
package param_step_counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(v)) r++;
    end
    return r;
  endfunction

  function automatic int presc_width(input int p);
    int w;
    w = clog2(p);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Enabled-cycle divider: tick marks the last
// cycle of each PRESCALE-long period.
module step_prescaler
  import param_step_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic CK,
  input  logic CLR,
  input  logic restart,
  input  logic EN,
  output logic tick
);

  localparam int PW = presc_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  assign tick = !EN && (cnt == LAST);

  always_ff @(posedge CK) begin
    if (CLR || restart) begin
      cnt <= '0;
    end else if (!EN) begin
      cnt <= tick ? '0 : cnt + PW'(1);
    end
  end

endmodule

// File: rtl/param_step_counter.sv
// Up/down counter with programmable step, modulus,
// wrap/saturate mode, load, prescaler and flags.
module param_step_counter
  import param_step_counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX      = 255,
  parameter int SATURATE = 0,
  parameter int PRESCALE = 1
) (
  input  logic             CK,
  input  logic             CLR,
  input  logic             EN,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] STEP,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             OVF
);

  localparam int W1 = WIDTH + 1;
  localparam logic [W1-1:0] MAXV = W1'(MAX);
  localparam logic [W1-1:0] MODV = W1'(MAX + 1);
  localparam logic MODE =
    (SATURATE != 0) ? MODE_SAT : MODE_WRAP;

  logic tick;

  step_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_pre (
    .CK      (CK),
    .CLR     (CLR),
    .restart (LOAD),
    .EN      (EN),
    .tick    (tick)
  );

  // One spare bit so over/under-range is seen
  // before anything is truncated back to WIDTH.
  logic [W1-1:0] qx;
  logic [W1-1:0] stx;
  logic [W1-1:0] sx;
  logic [W1-1:0] dx;
  logic [W1-1:0] sum;
  logic [W1-1:0] up_q;
  logic [W1-1:0] dn_q;
  logic [W1-1:0] ev_q;
  logic [W1-1:0] ld_q;
  logic          up_ovr;
  logic          dn_und;
  logic          ev_ovr;
  logic          ld_clamp;

  always_comb begin
    qx  = {1'b0, Q};
    stx = {1'b0, STEP};
    dx  = {1'b0, D};
    sx  = (stx > MAXV) ? MAXV : stx;
    sum = qx + sx;

    up_ovr = sum > MAXV;
    if (!up_ovr)
      up_q = sum;
    else if (MODE == MODE_SAT)
      up_q = MAXV;
    else
      up_q = sum - MODV;

    dn_und = sx > qx;
    if (!dn_und)
      dn_q = qx - sx;
    else if (MODE == MODE_SAT)
      dn_q = '0;
    else
      dn_q = qx + MODV - sx;

    ev_q   = UP ? up_q : dn_q;
    ev_ovr = UP ? up_ovr : dn_und;

    ld_clamp = dx > MAXV;
    ld_q     = ld_clamp ? MAXV : dx;
  end

  logic             do_ld;
  logic             do_ev;
  logic [WIDTH-1:0] q_nxt;
  logic             tc_nxt;
  logic             ovf_nxt;

  assign do_ld = LOAD;
  assign do_ev = !LOAD && tick;

  always_comb begin
    q_nxt   = Q;
    tc_nxt  = 1'b0;
    ovf_nxt = OVF;
    unique case (1'b1)
      do_ld: begin
        q_nxt   = WIDTH'(ld_q);
        ovf_nxt = OVF | ld_clamp;
      end
      do_ev: begin
        q_nxt   = WIDTH'(ev_q);
        tc_nxt  = ev_ovr;
        ovf_nxt = OVF | ev_ovr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CK) begin
    if (CLR) begin
      Q   <= '0;
      TC  <= 1'b0;
      OVF <= 1'b0;
    end else begin
      Q   <= q_nxt;
      TC  <= tc_nxt;
      OVF <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_param_step_counter.sv
// Scoreboard bench: six counter configurations share
// one stimulus stream and one reference model each.
module tb_param_step_counter;

  localparam int NI = 6;
  localparam int WS[NI]   = '{8, 8, 8, 8, 8, 4};
  localparam int MAXS[NI] = '{255, 9, 9, 9, 9, 15};
  localparam int SATS[NI] = '{0, 0, 1, 0, 0, 1};
  localparam int PRES[NI] = '{1, 1, 1, 4, 3, 2};

  logic       CK = 1'b0;
  logic       CLR, EN, UP, LOAD;
  logic [7:0] D, STEP;

  logic [7:0] qa[NI];
  logic       tca[NI];
  logic       ova[NI];
  logic [3:0] q5;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    param_step_counter #(
      .WIDTH    (8),
      .MAX      (MAXS[g]),
      .SATURATE (SATS[g]),
      .PRESCALE (PRES[g])
    ) u_dut (
      .CK   (CK),
      .CLR  (CLR),
      .EN   (EN),
      .UP   (UP),
      .LOAD (LOAD),
      .D    (D),
      .STEP (STEP),
      .Q    (qa[g]),
      .TC   (tca[g]),
      .OVF  (ova[g])
    );
  end

  param_step_counter #(
    .WIDTH    (4),
    .MAX      (15),
    .SATURATE (1),
    .PRESCALE (2)
  ) u_dut5 (
    .CK   (CK),
    .CLR  (CLR),
    .EN   (EN),
    .UP   (UP),
    .LOAD (LOAD),
    .D    (D[3:0]),
    .STEP (STEP[3:0]),
    .Q    (q5),
    .TC   (tca[5]),
    .OVF  (ova[5])
  );

  assign qa[5] = {4'b0, q5};

  always #5 CK = ~CK;

  typedef struct packed {
    logic [7:0] q;
    logic       tc;
    logic       ovf;
  } exp_t;

  exp_t sb[NI][$];

  int mq[NI];
  int mpc[NI];
  bit mtc[NI];
  bit mov[NI];

  int nchk = 0;
  int nerr = 0;

  task automatic check(string nm, int act, int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference: counts live in plain integers and the
  // period is just "event every PRESCALE enabled cycles".
  function automatic void mstep(int i, bit clr, bit ld,
                                bit en, bit up,
                                int d, int st);
    int mx, msk, dm, sm, s, v;
    mx  = MAXS[i];
    msk = (1 << WS[i]) - 1;
    dm  = d & msk;
    sm  = st & msk;
    if (clr) begin
      mq[i] = 0; mtc[i] = 0; mov[i] = 0; mpc[i] = 0;
    end else if (ld) begin
      if (dm > mx) begin
        mq[i] = mx; mov[i] = 1;
      end else begin
        mq[i] = dm;
      end
      mtc[i] = 0;
      mpc[i] = 0;
    end else if (!en) begin
      if (mpc[i] == PRES[i] - 1) begin
        mpc[i] = 0;
        s = (sm > mx) ? mx : sm;
        v = up ? mq[i] + s : mq[i] - s;
        mtc[i] = 0;
        if (v > mx) begin
          mq[i] = SATS[i] ? mx : v - (mx + 1);
          mtc[i] = 1; mov[i] = 1;
        end else if (v < 0) begin
          mq[i] = SATS[i] ? 0 : v + (mx + 1);
          mtc[i] = 1; mov[i] = 1;
        end else begin
          mq[i] = v;
        end
      end else begin
        mpc[i]++;
        mtc[i] = 0;
      end
    end else begin
      mtc[i] = 0;
    end
    sb[i].push_back(exp_t'{q: 8'(mq[i]),
                           tc: mtc[i],
                           ovf: mov[i]});
  endfunction

  task automatic cyc(bit clr, bit ld, bit en, bit up,
                     int d, int st);
    @(negedge CK);
    CLR  = clr;
    LOAD = ld;
    EN   = en;
    UP   = up;
    D    = 8'(d);
    STEP = 8'(st);
    for (int i = 0; i < NI; i++)
      mstep(i, clr, ld, en, up, d & 255, st & 255);
  endtask

  task automatic peek(int i, int q, int tc, int ov,
                      string nm);
    @(posedge CK);
    #2;
    check({nm, " q"}, int'(qa[i]), q);
    check({nm, " tc"}, int'(tca[i]), tc);
    check({nm, " ovf"}, int'(ova[i]), ov);
  endtask

  always @(posedge CK) begin
    #1;
    for (int i = 0; i < NI; i++) begin
      if (sb[i].size() > 0) begin
        exp_t e;
        e = sb[i].pop_front();
        check($sformatf("sb%0d q", i), int'(qa[i]), int'(e.q));
        check($sformatf("sb%0d tc", i), int'(tca[i]), int'(e.tc));
        check($sformatf("sb%0d ovf", i), int'(ova[i]), int'(e.ovf));
      end
    end
  end

  int seq10[7] = '{3, 6, 9, 2, 5, 8, 1};
  int tc10[7]  = '{0, 0, 0, 1, 0, 0, 1};
  int ov10[7]  = '{0, 0, 0, 1, 1, 1, 1};

  initial begin
    CLR = 1'b1; LOAD = 1'b0; EN = 1'b1;
    UP = 1'b1; D = '0; STEP = '0;

    cyc(1, 0, 0, 1, 0, 1);
    peek(0, 0, 0, 0, "reset");

    for (int k = 1; k <= 300; k++) begin
      cyc(0, 0, 0, 1, 0, 1);
      if (k == 255) peek(0, 255, 0, 0, "cnt255");
      if (k == 256) peek(0, 0, 1, 1, "wrap256");
      if (k == 257) peek(0, 1, 0, 1, "after wrap");
    end

    cyc(1, 0, 0, 1, 0, 3);
    for (int k = 0; k < 7; k++) begin
      cyc(0, 0, 0, 1, 0, 3);
      peek(1, seq10[k], tc10[k], ov10[k],
           $sformatf("mod10 %0d", k));
    end

    cyc(1, 0, 0, 0, 0, 3);
    cyc(0, 1, 0, 0, 4, 3);
    peek(2, 4, 0, 0, "sat load");
    cyc(0, 0, 0, 0, 0, 3);
    peek(2, 1, 0, 0, "sat 4-3");
    cyc(0, 0, 0, 0, 0, 3);
    peek(2, 0, 1, 1, "sat 1-3");
    cyc(0, 0, 0, 0, 0, 3);
    peek(2, 0, 1, 1, "sat hold");

    cyc(1, 0, 0, 1, 0, 1);
    cyc(0, 1, 1, 1, 12, 1);
    peek(1, 9, 0, 1, "load clamp");
    cyc(1, 1, 0, 1, 5, 1);
    peek(1, 0, 0, 0, "clr over load");
    cyc(0, 1, 1, 1, 7, 1);
    peek(1, 7, 0, 0, "load en off");

    cyc(1, 0, 0, 1, 0, 1);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 1, 0, 1);
    peek(3, 1, 0, 0, "pre4 first");
    cyc(0, 0, 0, 1, 0, 1);
    cyc(0, 0, 1, 1, 0, 1);
    cyc(0, 0, 1, 1, 0, 1);
    cyc(0, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 1, 0, 1);
    peek(3, 1, 0, 0, "pre4 frozen");
    cyc(0, 0, 0, 1, 0, 1);
    peek(3, 2, 0, 0, "pre4 delayed");
    cyc(0, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 1, 0, 1);
    cyc(0, 1, 0, 1, 0, 1);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, 0, 1);
    peek(3, 0, 0, 0, "pre4 restart");
    cyc(0, 0, 0, 1, 0, 1);
    peek(3, 1, 0, 0, "pre4 after load");

    cyc(1, 0, 0, 1, 0, 1);
    cyc(0, 1, 0, 1, 7, 1);
    cyc(0, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 1, 0, 1);
    peek(4, 7, 0, 0, "pre3 mid");
    cyc(1, 0, 0, 1, 0, 1);
    peek(4, 0, 0, 0, "pre3 clr");
    cyc(0, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 1, 0, 1);
    peek(4, 0, 0, 0, "pre3 wait");
    cyc(0, 0, 0, 1, 0, 1);
    peek(4, 1, 0, 0, "pre3 first");

    for (int n = 0; n < 3000; n++) begin
      bit clr, ld, en, up;
      int d, st;
      clr = ($urandom_range(0, 63) == 0);
      ld  = ($urandom_range(0, 15) == 0);
      en  = ($urandom_range(0, 3) == 0);
      up  = 1'($urandom_range(0, 1));
      d   = $urandom_range(0, 1) ? $urandom_range(0, 255)
                                 : $urandom_range(0, 20);
      st  = ($urandom_range(0, 3) == 0)
              ? $urandom_range(0, 255)
              : $urandom_range(0, 4);
      cyc(clr, ld, en, up, d, st);
    end

    @(posedge CK);
    #3;
    for (int i = 0; i < NI; i++)
      check($sformatf("drain%0d", i), sb[i].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule

// File: doc/param_step_counter.md
Name: param_step_counter

Overview:
- Parametrised successor to the 8-bit add-and-register counter: a WIDTH-bit up/down counter with programmable step, modulus, wrap or saturate mode, parallel load, prescaler, terminal-count pulse and sticky overflow flag.
- Used as a general event/timebase counter. It is driven by the standard 50% clock generator, and its value goes to DIP/LED-style probes and to downstream logic.

Parameters:
- WIDTH, 8, counter/data width in bits (>=2).
- MAX, 255, highest count value; the modulus is MAX+1; 1 <= MAX <= 2^WIDTH-1.
- SATURATE, 0, 0 = wrap modulo MAX+1, 1 = clamp at 0/MAX.
- PRESCALE, 1, number of enabled cycles per count event (>=1); 1 = count every enabled cycle.

Ports:
- CK, input, 1, clock, rising-edge active.
- CLR, input, 1, reset: synchronous, active-high.
- EN, input, 1, count enable, active-low (matches existing register family).
- UP, input, 1, 1 = count up, 0 = count down.
- LOAD, input, 1, synchronous parallel load, active-high.
- D, input, WIDTH, load value.
- STEP, input, WIDTH, increment/decrement amount per count event.
- Q, output, WIDTH, registered count value.
- TC, output, 1, registered one-cycle pulse: the count event in the previous cycle wrapped or saturated.
- OVF, output, 1, registered sticky flag: set on any wrap/saturation or load clamp.

Behaviour:
- All state changes on the rising CK edge. No asynchronous paths. Outputs come straight from registers (latency 1 cycle from input to Q/TC/OVF).
- Reset (CLR=1 at edge): Q=0, TC=0, OVF=0, prescaler count=0.
- Reset overrides everything, including mid-count and mid-prescale.
- Priority per edge: CLR > LOAD > count event > hold.
- LOAD=1 (CLR=0):
  - Q = D if D <= MAX; otherwise Q = MAX and OVF set.
  - TC=0. Prescaler reset to 0.
  - OVF otherwise keeps its value; LOAD does not clear OVF.
  - LOAD ignores EN.
- Prescaler: counts enabled cycles (EN=0, no CLR/LOAD) from 0 to PRESCALE-1.
  - A count event occurs on the edge where it is at PRESCALE-1; it then returns to 0.
  - EN=1 freezes the prescaler.
  - With PRESCALE=1 every enabled cycle is an event.
- Effective step s = min(STEP, MAX). A STEP of 0 is legal: Q holds, but an event still occurs (no TC).
- Arithmetic: internal width WIDTH+1, no truncation before the compare.
- Up event:
  - sum = Q + s.
  - sum <= MAX: Q = sum.
  - sum > MAX and wrap mode: Q = sum - (MAX+1).
  - sum > MAX and saturate mode: Q = MAX.
  - In both over-range cases TC=1 for one cycle and OVF set.
- Down event:
  - s <= Q: Q = Q - s.
  - s > Q and wrap mode: Q = Q + (MAX+1) - s.
  - s > Q and saturate mode: Q = 0.
  - In both under-range cases TC=1 and OVF set.
- Saturated hold: repeated events at MAX (up) or 0 (down) with s>0 re-pulse TC on every event.
- TC is 0 on every edge without a wrapping/saturating event.
- OVF is cleared only by CLR.
- UP, STEP and D are sampled at the event/load edge only. Changing them between events has no effect.

Decomposition:
- Shared package:
  - mode constants MODE_WRAP=0, MODE_SAT=1;
  - function clog2 for the prescaler width (max(1, clog2(PRESCALE))).
- One sub-module, step_prescaler: parameter PRESCALE; ports CK, CLR, restart (=LOAD), EN (active-low); output tick.
- The arithmetic, next-state and flag logic stay in param_step_counter.

Test Plan:
- Reset and count: WIDTH=8, MAX=255, STEP=1, UP=1, EN=0, run 300 cycles.
  - Q reaches 255, then 0 at cycle 256.
  - TC high exactly one cycle after the wrap; OVF=1 thereafter.
- Modulo-10 wrap: MAX=9, STEP=3, UP=1, from 0.
  - Q sequence 3,6,9,2,5,8,1.
  - TC after 9->2 and 8->1.
- Down with saturate: SATURATE=1, MAX=9, LOAD D=4, UP=0, STEP=3.
  - Q 4->1->0->0.
  - TC pulses on both saturating events; OVF=1.
- Load clamp and priority:
  - MAX=9: LOAD D=12 -> Q=9, OVF=1.
  - Same edge CLR=1 and LOAD=1 (D=5) -> Q=0, OVF=0.
  - LOAD with EN=1 -> Q=D.
- Prescaler: PRESCALE=4, STEP=1, EN=0 -> Q increments every 4th cycle.
  - EN=1 for 2 cycles mid-period -> next increment delayed 2 cycles.
  - LOAD restarts the period.
- Reset mid-operation: PRESCALE=3, prescaler at 2, Q=7, assert CLR one cycle.
  - Q=0, TC=0, OVF=0.
  - First increment lands exactly 3 enabled cycles after CLR deasserts.
